// File: rtl/reg_file.sv
// Architectural integer register file: two registered read ports, one writeback
// write port and a per-register pending scoreboard that reads back as a bubble.
package core;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          en;
  } rf_read_req_t;

  typedef struct packed {
    logic [XLEN-1:0] value;
    logic            valid;
    logic            done;
  } rf_read_rsp_t;
endpackage

module reg_file #(
  parameter int XLEN = core::XLEN,
  parameter int NREG = core::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  core::rf_read_req_t rs1_rf_read_req,
  input  core::rf_read_req_t rs2_rf_read_req,
  output core::rf_read_rsp_t rs1_rf_read_rsp,
  output core::rf_read_rsp_t rs2_rf_read_rsp,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [XLEN-1:0]    wr_value,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  input  logic               flush
);

  localparam int NPORT = 2;

  logic [XLEN-1:0]    regs_r [NREG];
  logic [NREG-1:0]    pend_r;
  logic [NREG-1:0]    pend_nxt_s;
  logic               wr_live_s;
  logic               rsv_live_s;

  core::rf_read_req_t req_s     [NPORT];
  core::rf_read_rsp_t rsp_s     [NPORT];
  logic [XLEN-1:0]    fwd_s     [NPORT];
  logic               vld_nxt_s [NPORT];

  logic               done_r    [NPORT];
  logic [AW-1:0]      cap_r     [NPORT];
  logic [XLEN-1:0]    val_r     [NPORT];
  logic               vld_r     [NPORT];

  assign req_s[0] = rs1_rf_read_req;
  assign req_s[1] = rs2_rf_read_req;
  assign rs1_rf_read_rsp = rsp_s[0];
  assign rs2_rf_read_rsp = rsp_s[1];

  assign wr_live_s  = wr_en  && (wr_addr  != {AW{1'b0}});
  assign rsv_live_s = rsv_en && (rsv_addr != {AW{1'b0}});

  // Next pending vector: write clears, reserve then sets (so it wins), flush overrides both.
  always_comb begin
    pend_nxt_s = pend_r;
    if (flush) begin
      pend_nxt_s = {NREG{1'b0}};
    end else begin
      pend_nxt_s[wr_addr]  = wr_live_s  ? 1'b0 : pend_nxt_s[wr_addr];
      pend_nxt_s[rsv_addr] = rsv_live_s ? 1'b1 : pend_nxt_s[rsv_addr];
    end
    pend_nxt_s[0] = 1'b0;
  end

  // Storage and scoreboard update; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
      pend_r <= {NREG{1'b0}};
    end else begin
      if (wr_live_s) begin
        regs_r[wr_addr] <= wr_value;
      end
      pend_r <= pend_nxt_s;
    end
  end

  // Per-port read value with same-cycle write forwarding, and next-cycle validity.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      if (req_s[p].addr == {AW{1'b0}}) begin
        fwd_s[p] = {XLEN{1'b0}};
      end else if (wr_en && (wr_addr == req_s[p].addr)) begin
        fwd_s[p] = wr_value;
      end else begin
        fwd_s[p] = regs_r[req_s[p].addr];
      end
      vld_nxt_s[p] = ~pend_nxt_s[req_s[p].addr];
    end
  end

  // Per-port captured request and response state, refreshed every cycle.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (rst) begin
        done_r[p] <= 1'b0;
        cap_r[p]  <= {AW{1'b0}};
        val_r[p]  <= {XLEN{1'b0}};
        vld_r[p]  <= 1'b0;
      end else begin
        done_r[p] <= req_s[p].en;
        cap_r[p]  <= req_s[p].addr;
        val_r[p]  <= fwd_s[p];
        vld_r[p]  <= vld_nxt_s[p];
      end
    end
  end

  // Response masking: done only while the captured request is still being presented.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      rsp_s[p].done  = done_r[p] && req_s[p].en && (req_s[p].addr == cap_r[p]) && !rst;
      rsp_s[p].valid = rsp_s[p].done && vld_r[p];
      if (rst) begin
        rsp_s[p].value = {XLEN{1'b0}};
      end else begin
        rsp_s[p].value = val_r[p];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes per-cycle expected responses,
// a negedge monitor pops and compares them against both read ports.
module tb_reg_file;

  typedef struct {
    int          cyc;
    logic        done;
    logic        valid;
    logic [31:0] value;
  } exp_t;

  logic               clk;
  logic               rst;
  core::rf_read_req_t rs1_req;
  core::rf_read_req_t rs2_req;
  core::rf_read_rsp_t rs1_rsp;
  core::rf_read_rsp_t rs2_rsp;
  logic               wr_en;
  logic [4:0]         wr_addr;
  logic [31:0]        wr_value;
  logic               rsv_en;
  logic [4:0]         rsv_addr;
  logic               flush;

  exp_t q1[$];
  exp_t q2[$];
  int   n_cmp;
  int   n_bad;
  int   cyc_no;

  reg_file dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_rf_read_req (rs1_req),
    .rs2_rf_read_req (rs2_req),
    .rs1_rf_read_rsp (rs1_rsp),
    .rs2_rf_read_rsp (rs2_rsp),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_value        (wr_value),
    .rsv_en          (rsv_en),
    .rsv_addr        (rsv_addr),
    .flush           (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic d, input logic v, input logic [31:0] val);
    exp_t e;
    e.cyc   = cyc_no;
    e.done  = d;
    e.valid = v;
    e.value = val;
    return e;
  endfunction

  task automatic check(input int port, input exp_t e, input core::rf_read_rsp_t r);
    n_cmp++;
    if (r.done !== e.done || r.valid !== e.valid || r.value !== e.value) begin
      n_bad++;
      $display("FAIL rs%0d_cyc%0d: got done=%0d valid=%0d value=%h, want done=%0d valid=%0d value=%h",
               port, e.cyc, r.done, r.valid, r.value, e.done, e.valid, e.value);
    end
  endtask

  // Monitor: one expectation per port per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (q1.size() > 0) check(1, q1.pop_front(), rs1_rsp);
    if (q2.size() > 0) check(2, q2.pop_front(), rs2_rsp);
  end

  task automatic cyc(input exp_t e1, input exp_t e2);
    q1.push_back(e1);
    q2.push_back(e2);
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    flush  = 1'b0;
    cyc_no++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc_no = -2;
    rst = 1'b1;
    rs1_req = '0; rs2_req = '0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_value = 32'd0;
    rsv_en = 1'b0; rsv_addr = 5'd0; flush = 1'b0;
    @(posedge clk); #1;

    // Reset: all outputs zero.
    rs1_req.en = 1'b1; rs1_req.addr = 5'd5;
    cyc(mk(1'b0, 1'b0, 32'h0), mk(1'b0, 1'b0, 32'h0));
    cyc(mk(1'b0, 1'b0, 32'h0), mk(1'b0, 1'b0, 32'h0));
    rst = 1'b0;
    // C0: new request, latency 1.
    cyc(mk(1'b0, 1'b0, 32'h0), mk(1'b0, 1'b0, 32'h0));
    // C1
    cyc(mk(1'b1, 1'b1, 32'h0), mk(1'b0, 1'b0, 32'h0));
    // C2: rs2 new addr 7.
    rs2_req.en = 1'b1; rs2_req.addr = 5'd7;
    cyc(mk(1'b1, 1'b1, 32'h0), mk(1'b0, 1'b0, 32'h0));
    // C3: write x7 while rs2 holds 7; rs1 newly requests 7.
    wr_en = 1'b1; wr_addr = 5'd7; wr_value = 32'hDEADBEEF;
    rs1_req.addr = 5'd7;
    cyc(mk(1'b0, 1'b0, 32'h0), mk(1'b1, 1'b1, 32'h0));
    // C4: both see the write.
    cyc(mk(1'b1, 1'b1, 32'hDEADBEEF), mk(1'b1, 1'b1, 32'hDEADBEEF));
    // C5: reserve x3 and read it in the same cycle.
    rsv_en = 1'b1; rsv_addr = 5'd3; rs1_req.addr = 5'd3;
    cyc(mk(1'b0, 1'b0, 32'hDEADBEEF), mk(1'b1, 1'b1, 32'hDEADBEEF));
    // C6: bubble.
    cyc(mk(1'b1, 1'b0, 32'h0), mk(1'b1, 1'b1, 32'hDEADBEEF));
    // C7: producer writes x3.
    wr_en = 1'b1; wr_addr = 5'd3; wr_value = 32'h11;
    cyc(mk(1'b1, 1'b0, 32'h0), mk(1'b1, 1'b1, 32'hDEADBEEF));
    // C8
    cyc(mk(1'b1, 1'b1, 32'h11), mk(1'b1, 1'b1, 32'hDEADBEEF));
    // C9: same-cycle reserve and write of x9; rs2 requests 9.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_value = 32'h22;
    rs2_req.addr = 5'd9;
    cyc(mk(1'b1, 1'b1, 32'h11), mk(1'b0, 1'b0, 32'hDEADBEEF));
    // C10: data written, still pending; flush now.
    flush = 1'b1;
    cyc(mk(1'b1, 1'b1, 32'h11), mk(1'b1, 1'b0, 32'h22));
    // C11: flush cleared pending; preload x4.
    wr_en = 1'b1; wr_addr = 5'd4; wr_value = 32'h44;
    cyc(mk(1'b1, 1'b1, 32'h11), mk(1'b1, 1'b1, 32'h22));
    // C12: write and reserve x0, both ports read x0.
    wr_en = 1'b1; wr_addr = 5'd0; wr_value = 32'hFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rs1_req.addr = 5'd0; rs2_req.addr = 5'd0;
    cyc(mk(1'b0, 1'b0, 32'h11), mk(1'b0, 1'b0, 32'h22));
    // C13: x0 reads zero and valid; preload x6.
    wr_en = 1'b1; wr_addr = 5'd6; wr_value = 32'h66;
    cyc(mk(1'b1, 1'b1, 32'h0), mk(1'b1, 1'b1, 32'h0));
    // C14: rs1 to x4.
    rs1_req.addr = 5'd4;
    cyc(mk(1'b0, 1'b0, 32'h0), mk(1'b1, 1'b1, 32'h0));
    // C15
    cyc(mk(1'b1, 1'b1, 32'h44), mk(1'b1, 1'b1, 32'h0));
    // C16: address change while held.
    rs1_req.addr = 5'd6;
    cyc(mk(1'b0, 1'b0, 32'h44), mk(1'b1, 1'b1, 32'h0));
    // C17
    cyc(mk(1'b1, 1'b1, 32'h66), mk(1'b1, 1'b1, 32'h0));
    // C18: reset mid-hold.
    rst = 1'b1;
    cyc(mk(1'b0, 1'b0, 32'h0), mk(1'b0, 1'b0, 32'h0));
    // C19: one cycle before done returns.
    rst = 1'b0;
    cyc(mk(1'b0, 1'b0, 32'h0), mk(1'b0, 1'b0, 32'h0));
    // C20: regs were cleared; write x6 forwarded into the capture.
    wr_en = 1'b1; wr_addr = 5'd6; wr_value = 32'h77;
    cyc(mk(1'b1, 1'b1, 32'h0), mk(1'b1, 1'b1, 32'h0));
    // C21: en low masks done/valid immediately.
    rs1_req.en = 1'b0;
    cyc(mk(1'b0, 1'b0, 32'h77), mk(1'b1, 1'b1, 32'h0));

    @(negedge clk); #1;
    n_cmp++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d left, want 0/0", q1.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
